// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and RMW access sequencer for the data memory
module dmem_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int MEM_BYTES = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [1:0]        req0_size,
  input  logic              req0_unsigned,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [1:0]        req1_size,
  input  logic              req1_unsigned,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_wrt_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rbuf_q, rbuf_d;

  logic              gnt0, gnt1;
  logic [31:0]       load_data;

  // On contention the requester that did not win last time gets the slot.
  assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

  always_comb begin
    load_data = 32'h0;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, rbuf_q[7:0]}  : {{24{rbuf_q[7]}}, rbuf_q[7:0]};
      2'b01:   load_data = uns_q ? {16'h0, rbuf_q[15:0]} : {{16{rbuf_q[15]}}, rbuf_q[15:0]};
      default: load_data = rbuf_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    id_d           = id_q;
    we_d           = we_q;
    size_d         = size_q;
    uns_d          = uns_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    rbuf_d         = rbuf_q;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    rsp0_valid     = 1'b0;
    rsp0_rdata     = 32'h0;
    rsp0_err       = 1'b0;
    rsp1_valid     = 1'b0;
    rsp1_rdata     = 32'h0;
    rsp1_err       = 1'b0;
    mem_wrt_en     = 1'b0;
    mem_address    = '0;
    mem_write_data = 32'h0;

    case (state_q)
      IDLE: begin
        // Gated by reset so ready stays low while the block is held in reset.
        req0_ready = gnt0 & rst;
        req1_ready = gnt1 & rst;
        if (gnt0 | gnt1) begin
          id_d         = gnt1;
          last_grant_d = gnt1;
          we_d         = gnt1 ? req1_we       : req0_we;
          size_d       = gnt1 ? req1_size     : req0_size;
          uns_d        = gnt1 ? req1_unsigned : req0_unsigned;
          addr_d       = gnt1 ? req1_addr     : req0_addr;
          wdata_d      = gnt1 ? req1_wdata    : req0_wdata;
          err_d        = (addr_d > MAX_ADDR) || (size_d == 2'b11);
          if (err_d)                          state_d = RESP;
          else if (we_d && size_d == 2'b10)   state_d = WR;
          else                                state_d = RD;
        end
      end
      RD: begin
        mem_address = addr_q;
        rbuf_d      = mem_read_data;
        state_d     = we_q ? WR : RESP;
      end
      WR: begin
        mem_wrt_en  = 1'b1;
        mem_address = addr_q;
        case (size_q)
          2'b00:   mem_write_data = {rbuf_q[31:8],  wdata_q[7:0]};
          2'b01:   mem_write_data = {rbuf_q[31:16], wdata_q[15:0]};
          default: mem_write_data = wdata_q;
        endcase
        state_d = RESP;
      end
      RESP: begin
        mem_address = addr_q;
        if (id_q) begin
          rsp1_valid = 1'b1;
          rsp1_err   = err_q;
          rsp1_rdata = (!we_q && !err_q) ? load_data : 32'h0;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_err   = err_q;
          rsp0_rdata = (!we_q && !err_q) ? load_data : 32'h0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      err_q        <= 1'b0;
      rbuf_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rbuf_q       <= rbuf_d;
    end
  end

endmodule
